// File: rtl/sync_debounce_bank.sv
// Multi-channel input conditioner: N-stage synchroniser, consecutive-sample debounce and
// registered edge pulses per channel. Define STICKY_REQ_EN to add sticky request latches.
module sync_debounce_bank #(
  parameter int CHANNELS  = 4,
  parameter int STAGES    = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                Reset_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
`ifdef STICKY_REQ_EN
  ,
  input  logic [CHANNELS-1:0] req_clear,
  output logic [CHANNELS-1:0] req_sticky
`endif
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_debounce_bank: STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("sync_debounce_bank: DB_CYCLES must be >= 1");
  end

  logic [CHANNELS-1:0] stage_q [STAGES];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CHANNELS-1:0] raw;

  assign raw = stage_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      sync_out   <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      stage_q[0] <= async_in;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        rise_pulse[i] <= 1'b0;
        fall_pulse[i] <= 1'b0;
        if (raw[i] == sync_out[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          // Mismatch has persisted DB_CYCLES samples: commit the new level.
          sync_out[i]   <= raw[i];
          rise_pulse[i] <= raw[i];
          fall_pulse[i] <= ~raw[i];
          cnt_q[i]      <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef STICKY_REQ_EN
  logic [CHANNELS-1:0] rise_set;

  // Mirrors the condition that loads rise_pulse, so set lands on the same edge.
  always_comb begin
    rise_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rise_set[i] = (raw[i] != sync_out[i]) && (cnt_q[i] == CntMax) && raw[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      req_sticky <= '0;
    end else begin
      req_sticky <= rise_set | (req_sticky & ~req_clear);
    end
  end
`else
  // No sticky request state in this build.
`endif

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank at CHANNELS=4, STAGES=2, DB_CYCLES=4.
module tb_sync_debounce_bank;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic [3:0] async_in;
  logic [3:0] sync_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
`ifdef STICKY_REQ_EN
  logic [3:0] req_clear;
  logic [3:0] req_sticky;
`endif

  int checks = 0;
  int errors = 0;

  sync_debounce_bank #(
    .CHANNELS (4),
    .STAGES   (2),
    .DB_CYCLES(4)
  ) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .async_in  (async_in),
    .sync_out  (sync_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`ifdef STICKY_REQ_EN
    ,
    .req_clear (req_clear),
    .req_sticky(req_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expect {sync_out, rise_pulse, fall_pulse}.
  task automatic check_out(input string tag, input logic [3:0] s, input logic [3:0] r,
                           input logic [3:0] f);
    check({tag, "_sync"}, {28'b0, sync_out}, {28'b0, s});
    check({tag, "_rise"}, {28'b0, rise_pulse}, {28'b0, r});
    check({tag, "_fall"}, {28'b0, fall_pulse}, {28'b0, f});
  endtask

  initial begin
    Reset_n  = 1'b0;
    async_in = 4'hF;
`ifdef STICKY_REQ_EN
    req_clear = 4'h0;
`endif

    // Reset held with all inputs high: everything stays 0.
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out("reset_hold", 4'h0, 4'h0, 4'h0);
    end

    // Release: inputs already high become a rise at the 6th edge.
    Reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("release_wait", 4'h0, 4'h0, 4'h0);
    end
    tick();
    check_out("release_rise", 4'hF, 4'hF, 4'h0);
    tick();
    check_out("release_after", 4'hF, 4'h0, 4'h0);

    // Drop channels 0,1,3; keep channel 2 high.
    async_in = 4'h4;
    for (int k = 1; k <= 5; k++) tick();
    check_out("drop_pre", 4'hF, 4'h0, 4'h0);
    tick();
    check_out("drop_fall", 4'h4, 4'h0, 4'hB);
    tick();
    check_out("drop_after", 4'h4, 4'h0, 4'h0);

    // Clean rise on channel 0.
    async_in = 4'h5;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("rise0_wait", 4'h4, 4'h0, 4'h0);
    end
    tick();
    check_out("rise0_edge", 4'h5, 4'h1, 4'h0);
    tick();
    check_out("rise0_after", 4'h5, 4'h0, 4'h0);

    // 3-cycle glitch on channel 1 is rejected.
    async_in = 4'h7;
    tick();
    check_out("glitch3", 4'h5, 4'h0, 4'h0);
    tick();
    check_out("glitch3", 4'h5, 4'h0, 4'h0);
    tick();
    check_out("glitch3", 4'h5, 4'h0, 4'h0);
    async_in = 4'h5;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out("glitch3_tail", 4'h5, 4'h0, 4'h0);
    end

    // 4-cycle pulse on channel 1: high after edge 6, low after edge 10.
    async_in = 4'h7;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) async_in = 4'h5;
      tick();
      check_out("pulse4", (k >= 6 && k < 10) ? 4'h7 : 4'h5, (k == 6) ? 4'h2 : 4'h0,
                (k == 10) ? 4'h2 : 4'h0);
      if (k == 4) async_in = 4'h5;
    end

    // Clean fall on channel 2.
    async_in = 4'h1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("fall2_wait", 4'h5, 4'h0, 4'h0);
    end
    tick();
    check_out("fall2_edge", 4'h1, 4'h0, 4'h4);
    tick();
    check_out("fall2_after", 4'h1, 4'h0, 4'h0);

    // Channel 3 rises; reset lands when its count is 2.
    async_in = 4'h9;
    for (int k = 1; k <= 4; k++) tick();
    check_out("midreset_pre", 4'h1, 4'h0, 4'h0);
    Reset_n = 1'b0;
    tick();
    check_out("midreset_clr", 4'h0, 4'h0, 4'h0);
    Reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("midreset_wait", 4'h0, 4'h0, 4'h0);
    end
    tick();
    check_out("midreset_rise", 4'h9, 4'h9, 4'h0);
    tick();
    check_out("midreset_after", 4'h9, 4'h0, 4'h0);

`ifdef STICKY_REQ_EN
    check("sticky_set", {28'b0, req_sticky}, 32'h9);
    req_clear = 4'hF;
    tick();
    check("sticky_clr", {28'b0, req_sticky}, 32'h0);
    req_clear = 4'h0;

    // Channel 0 falls, then rises again with clear held across the pulse.
    async_in = 4'h8;
    for (int k = 1; k <= 7; k++) tick();
    check_out("sticky_fall", 4'h8, 4'h0, 4'h0);
    async_in  = 4'h9;
    req_clear = 4'h1;
    for (int k = 1; k <= 5; k++) tick();
    check("sticky_wait", {28'b0, req_sticky}, 32'h0);
    tick();
    check_out("sticky_rise", 4'h9, 4'h1, 4'h0);
    check("sticky_setwins", {28'b0, req_sticky}, 32'h1);
    tick();
    check("sticky_clr_next", {28'b0, req_sticky}, 32'h0);
    req_clear = 4'h0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
